// File: rtl/pxl_mem_arbiter.sv
// Three-requester frame RAM arbiter: burst-limited round-robin grant with registered RAM port.
// Define PXL_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (0 > 1 > 2).
module pxl_mem_arbiter #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, RELEASE = 2'd2} state_t;

  localparam int unsigned   BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_t            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [BW-1:0]     burst_q, burst_d, burst_inc;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, own_addr;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, own_wdata;
  logic [2:0]        rd_pend_q, rd_pend_d, rvalid_q;
  logic [1:0]        win_idx;
  logic              access, own_we, others;

  always_comb begin
    access    = |(gnt_q & req);
    own_we    = |(gnt_q & we);
    others    = |(req & ~gnt_q);
    burst_inc = burst_q + BW'(1);
    own_addr  = gnt_q[0] ? addr0  : (gnt_q[1] ? addr1  : addr2);
    own_wdata = gnt_q[0] ? wdata0 : (gnt_q[1] ? wdata1 : wdata2);
  end

  always_comb begin
    win_idx = 2'd0;
`ifdef PXL_ARB_FIXED_PRIO_EN
    if (req[0])      win_idx = 2'd0;
    else if (req[1]) win_idx = 2'd1;
    else             win_idx = 2'd2;
`else
    // Search begins one past the last owner and wraps.
    case (last_owner_q)
      2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        burst_d = '0;
        if (|req) begin
          state_d      = OWN;
          gnt_d        = 3'b001 << win_idx;
          last_owner_d = win_idx;
        end
      end
      OWN: begin
        if (!access) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (burst_inc == BURST_MAX) begin
          // Burst limit only forces a hand-off when someone else is waiting.
          burst_d = '0;
          if (others) begin
            state_d = RELEASE;
            gnt_d   = '0;
          end
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_en_d    = access;
    mem_we_d    = access & own_we;
    mem_addr_d  = access ? own_addr  : mem_addr_q;
    mem_wdata_d = access ? own_wdata : mem_wdata_q;
    rd_pend_d   = (access && !own_we) ? gnt_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_owner_q <= 2'd2;
      burst_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      rvalid_q     <= rd_pend_q;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign rvalid    = rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // RAM output is already registered and lines up with rvalid; gate it so rdata reads zero otherwise.
  assign rdata     = (|rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_pxl_mem_arbiter.sv
// Directed self-checking bench for pxl_mem_arbiter (default round-robin build).
module tb_pxl_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we;
  logic [16:0] addr0, addr1, addr2;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  pxl_mem_arbiter #(.ADDR_W(17), .DATA_W(8), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [16:0] a);
    return a[7:0] ^ 8'hA5 ^ a[16:9];
  endfunction

  // Synchronous-read frame RAM: data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= pix(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; we = '0;
    addr0 = '0; addr1 = '0; addr2 = '0; wdata0 = '0; wdata1 = '0; wdata2 = '0;
    #3 reset = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000)    begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    checks++; if (rdata !== 8'h00)   begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (mem_en !== 1'b0)   begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0)   begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 17'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL idle_gnt got=%b exp=000", gnt); end
  endtask

  // All three requesting from reset: 0,1,2 each own 16 accesses with a 2-cycle gap between owners.
  task automatic test_rr_burst();
    logic [2:0] exp;
    req = 3'b111; we = 3'b000;
    addr0 = 17'h00010; addr1 = 17'h00020; addr2 = 17'h00030;
    for (int k = 0; k < 72; k++) begin
      step();
      exp = ((k % 18) < 16) ? (3'b001 << ((k / 18) % 3)) : 3'b000;
      checks++;
      if (gnt !== exp || busy !== (|exp)) begin
        failures++;
        $display("FAIL rr_gnt k=%0d got=%b busy=%b exp=%b", k, gnt, busy, exp);
      end
    end
    req = 3'b000;
    repeat (5) step();
  endtask

  task automatic test_single_read();
    req = 3'b010; we = 3'b000; addr1 = 17'h00105;
    step();
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rd_gnt got=%b exp=010", gnt); end
    step();
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00105) begin
      failures++; $display("FAIL rd_mem en=%b we=%b addr=%h exp en=1 we=0 addr=00105", mem_en, mem_we, mem_addr);
    end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rd_early_rvalid got=%b exp=000", rvalid); end
    req = 3'b000;
    step();
    checks++; if (rvalid !== 3'b010 || rdata !== 8'hA0) begin
      failures++; $display("FAIL rd_data rvalid=%b rdata=%h exp rvalid=010 rdata=a0", rvalid, rdata);
    end
    checks++; if (gnt !== 3'b000 || mem_en !== 1'b0) begin
      failures++; $display("FAIL rd_release gnt=%b mem_en=%b exp gnt=000 mem_en=0", gnt, mem_en);
    end
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rd_single_pulse got=%b exp=000", rvalid); end
    repeat (3) step();
  endtask

  // Lone requester streams 40 writes through the burst limit without losing its grant.
  task automatic test_stream();
    logic [16:0] base;
    base = 17'h10000;
    req = 3'b001; we = 3'b001;
    for (int n = 0; n <= 40; n++) begin
      step();
      if (n < 40) begin
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL st_gnt n=%0d got=%b exp=001", n, gnt); end
      end
      if (n >= 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== base + 17'(n - 1) ||
            mem_wdata !== (8'(n - 1) ^ 8'hC3)) begin
          failures++;
          $display("FAIL st_mem n=%0d en=%b we=%b addr=%h data=%h exp addr=%h data=%h", n, mem_en, mem_we,
                   mem_addr, mem_wdata, base + 17'(n - 1), 8'(n - 1) ^ 8'hC3);
        end
      end
      if (n < 40) begin
        addr0 = base + 17'(n); wdata0 = 8'(n) ^ 8'hC3;
      end else begin
        req = 3'b000;
      end
    end
    step();
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== base + 17'd39) begin
      failures++; $display("FAIL st_hold en=%b we=%b addr=%h exp en=0 we=0 addr=%h", mem_en, mem_we, mem_addr, base + 17'd39);
    end
    we = 3'b000;
    repeat (4) step();
  endtask

  task automatic test_handoff();
    req = 3'b001; addr0 = 17'h00400; addr2 = 17'h00500;
    step();
    req = 3'b101;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL ho_own c=%0d got=%b exp=001", c, gnt); end
      if (c == 4) req = 3'b100;
      step();
    end
    checks++; if (gnt !== 3'b000 || mem_en !== 1'b0) begin
      failures++; $display("FAIL ho_release gnt=%b mem_en=%b exp gnt=000 mem_en=0", gnt, mem_en);
    end
    step();
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL ho_idle got=%b exp=000", gnt); end
    step();
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL ho_next got=%b exp=100", gnt); end
    req = 3'b000;
    repeat (4) step();
  endtask

  task automatic test_reset_midburst();
    req = 3'b100; we = 3'b000; addr2 = 17'h00333; addr0 = 17'h00042;
    step();
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL rm_own got=%b exp=100", gnt); end
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000 || rvalid !== 3'b000 || rdata !== 8'h00 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_async gnt=%b rvalid=%b rdata=%h busy=%b exp all 0", gnt, rvalid, rdata, busy);
    end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 17'h0 || mem_wdata !== 8'h0) begin
      failures++; $display("FAIL rm_async_mem en=%b we=%b addr=%h data=%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    reset = 1'b1; req = 3'b111;
    checks++; if (gnt !== 3'b000 || rvalid !== 3'b000) begin
      failures++; $display("FAIL rm_rel gnt=%b rvalid=%b exp 000 000", gnt, rvalid);
    end
    step();
    checks++; if (gnt !== 3'b001 || rvalid !== 3'b000) begin
      failures++; $display("FAIL rm_first gnt=%b rvalid=%b exp 001 000", gnt, rvalid);
    end
    step();
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rm_stale got=%b exp=000", rvalid); end
    step();
    checks++; if (rvalid !== 3'b001 || rdata !== 8'hE7) begin
      failures++; $display("FAIL rm_newread rvalid=%b rdata=%h exp 001 e7", rvalid, rdata);
    end
    req = 3'b000;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_rr_burst();
    test_single_read();
    test_stream();
    test_handoff();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
